// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds HH:MM BCD digits from a multiplexed seven-segment bus.
// Publishes only after STABLE_FRAMES identical clean scans; drops timeVal when scanning stops.
module seg_scan_decoder #(
    parameter int SETTLE        = 2,
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT       = 1000000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] seg,
    input  logic [7:0] an,
    output logic [3:0] onesMin,
    output logic [3:0] tensMin,
    output logic [3:0] onesHour,
    output logic [3:0] tensHour,
    output logic       colonOn,
    output logic       timeVal,
    output logic       newTime,
    output logic       segErr,
    output logic       anErr
);
    localparam logic [3:0]  ST    = 4'(SETTLE);
    localparam logic [3:0]  ST_M1 = 4'(SETTLE - 1);
    localparam logic [3:0]  SF    = 4'(STABLE_FRAMES);
    localparam logic [23:0] TO    = 24'(TIMEOUT);
    localparam logic [23:0] TO_M1 = 24'(TIMEOUT - 1);

    function automatic logic [3:0] dec(input logic [6:0] s);
        case (s)
            7'h40:   dec = 4'd0;
            7'h79:   dec = 4'd1;
            7'h24:   dec = 4'd2;
            7'h30:   dec = 4'd3;
            7'h19:   dec = 4'd4;
            7'h12:   dec = 4'd5;
            7'h02:   dec = 4'd6;
            7'h78:   dec = 4'd7;
            7'h00:   dec = 4'd8;
            7'h10:   dec = 4'd9;
            default: dec = 4'hF;
        endcase
    endfunction

    logic [7:0]  seg_q, an_q, an_p_q;
    logic [3:0]  sett_q, sett_d;
    logic [15:0] fr_q, fr_d;
    logic        col_q, col_d;
    logic [3:0]  seen_q, seen_d;
    logic [16:0] prev_q, frame, out_q;
    logic [3:0]  stable_q, stable_d;
    logic [23:0] to_q, to_d;
    logic        tv_q, nt_q, se_q, ae_q;
    logic        same, cap, legal, blank, wr, done, bad, pub, to_hit;
    logic [1:0]  idx;
    logic [3:0]  digit;

    always_comb begin
        same   = an_q == an_p_q;
        sett_d = !same ? 4'd0 : (sett_q == ST ? ST : sett_q + 4'd1);
        cap    = same && sett_q == ST_M1;
        legal  = an_q[7:4] == 4'hF && (an_q[3:0] inside {4'hE, 4'hD, 4'hB, 4'h7});
        blank  = an_q == 8'hFF;
        idx    = an_q[3:0] == 4'hE ? 2'd0 : an_q[3:0] == 4'hD ? 2'd1 : an_q[3:0] == 4'hB ? 2'd2 : 2'd3;
        digit  = dec(seg_q[6:0]);
        wr     = cap && legal;
        fr_d   = fr_q;
        col_d  = col_q;
        seen_d = seen_q;
        if (wr) begin
            fr_d[{idx, 2'b00} +: 4] = digit;
            col_d       = idx == 2'd2 ? ~seg_q[7] : col_q;
            seen_d[idx] = 1'b1;
        end
        done  = wr && seen_d == 4'hF;
        frame = {col_d, fr_d};
        bad   = fr_d[3:0] == 4'hF || fr_d[7:4] == 4'hF || fr_d[11:8] == 4'hF || fr_d[15:12] == 4'hF;
        stable_d = !done ? stable_q : bad ? 4'd0 : frame != prev_q ? 4'd1 :
                   (stable_q == SF ? SF : stable_q + 4'd1);
        pub    = done && !bad && stable_d == SF;
        to_hit = !done && to_q == TO_M1;
        to_d   = done ? 24'd0 : (to_q == TO ? TO : to_q + 24'd1);
        if (done || to_hit) seen_d = 4'h0;
        if (to_hit) stable_d = 4'd0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            seg_q    <= 8'hFF;
            an_q     <= 8'hFF;
            an_p_q   <= 8'hFF;
            sett_q   <= 4'd0;
            fr_q     <= 16'h0;
            col_q    <= 1'b0;
            seen_q   <= 4'h0;
            prev_q   <= 17'h0;
            stable_q <= 4'd0;
            to_q     <= 24'd0;
            out_q    <= 17'h0;
            tv_q     <= 1'b0;
            nt_q     <= 1'b0;
            se_q     <= 1'b0;
            ae_q     <= 1'b0;
        end else begin
            seg_q    <= seg;
            an_q     <= an;
            an_p_q   <= an_q;
            sett_q   <= sett_d;
            fr_q     <= fr_d;
            col_q    <= col_d;
            seen_q   <= seen_d;
            stable_q <= stable_d;
            to_q     <= to_d;
            if (done) prev_q <= frame;
            if (pub) out_q <= frame;
            tv_q     <= pub ? 1'b1 : to_hit ? 1'b0 : tv_q;
            nt_q     <= pub && (frame != out_q || !tv_q);
            se_q     <= se_q | (wr && digit == 4'hF);
            ae_q     <= ae_q | (cap && !legal && !blank);
        end
    end

    assign {colonOn, tensHour, onesHour, tensMin, onesMin} = out_q;
    assign timeVal = tv_q;
    assign newTime = nt_q;
    assign segErr  = se_q;
    assign anErr   = ae_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan sequences against hand-computed display values.
module tb_seg_scan_decoder;
    localparam int TO = 3000;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] seg = 8'hFF;
    logic [7:0] an = 8'hFF;
    logic [3:0] onesMin, tensMin, onesHour, tensHour;
    logic       colonOn, timeVal, newTime, segErr, anErr;
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;

    seg_scan_decoder #(.SETTLE(2), .STABLE_FRAMES(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rstN(rstN), .seg(seg), .an(an),
        .onesMin(onesMin), .tensMin(tensMin), .onesHour(onesHour), .tensHour(tensHour),
        .colonOn(colonOn), .timeVal(timeVal), .newTime(newTime),
        .segErr(segErr), .anErr(anErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (newTime === 1'b1) pulses++;

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 8'hC0;
            4'd1:    enc = 8'hF9;
            4'd2:    enc = 8'hA4;
            4'd3:    enc = 8'hB0;
            4'd4:    enc = 8'h99;
            4'd5:    enc = 8'h92;
            4'd6:    enc = 8'h82;
            4'd7:    enc = 8'hF8;
            4'd8:    enc = 8'h80;
            default: enc = 8'h90;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dwell(input logic [7:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_raw(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
        dwell(8'hFE, s0, 50);
        dwell(8'hFD, s1, 50);
        dwell(8'hFB, s2, 50);
        dwell(8'hF7, s3, 50);
    endtask

    task automatic frame(input logic [3:0] th, input logic [3:0] oh,
                         input logic [3:0] tm, input logic [3:0] om, input logic col);
        logic [7:0] s2;
        s2 = enc(oh);
        s2[7] = ~col;
        frame_raw(enc(om), enc(tm), s2, enc(th));
    endtask

    function automatic logic [15:0] digits();
        return {tensHour, onesHour, tensMin, onesMin};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_digits", 32'(digits()), 32'h0);
        chk("reset_flags", {27'd0, colonOn, timeVal, newTime, segErr, anErr}, 32'h0);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        // 12:34 needs three identical frames
        frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        chk("two_frames_not_valid", 32'(timeVal), 32'd0);
        frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        chk("pub_1234_digits", 32'(digits()), 32'h1234);
        chk("pub_1234_colon", 32'(colonOn), 32'd1);
        chk("pub_1234_valid", 32'(timeVal), 32'd1);
        chk("pub_1234_pulses", 32'(pulses), 32'd1);
        // change to 12:35
        frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1);
        frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1);
        chk("hold_1234_digits", 32'(digits()), 32'h1234);
        chk("hold_1234_pulses", 32'(pulses), 32'd1);
        frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1);
        chk("pub_1235_digits", 32'(digits()), 32'h1235);
        chk("pub_1235_pulses", 32'(pulses), 32'd2);
        frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1);
        frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1);
        chk("reconfirm_no_pulse", 32'(pulses), 32'd2);
        chk("no_seg_err_yet", 32'(segErr), 32'd0);
        // blank pattern on tens-min slot
        frame_raw(enc(4'd5), 8'h7F, 8'h24, enc(4'd1));
        chk("seg_err_set", 32'(segErr), 32'd1);
        chk("bad_frame_digits", 32'(digits()), 32'h1235);
        chk("bad_frame_valid", 32'(timeVal), 32'd1);
        frame(4'd1, 4'd2, 4'd3, 4'd6, 1'b1);
        frame(4'd1, 4'd2, 4'd3, 4'd6, 1'b1);
        chk("after_bad_hold", 32'(digits()), 32'h1235);
        frame(4'd1, 4'd2, 4'd3, 4'd6, 1'b1);
        chk("pub_1236_digits", 32'(digits()), 32'h1236);
        chk("pub_1236_pulses", 32'(pulses), 32'd3);
        // one-cycle illegal glitch, then a held illegal select
        dwell(8'hFF, 8'hFF, 5);
        dwell(8'hFC, enc(4'd9), 1);
        dwell(8'hFF, 8'hFF, 8);
        chk("glitch_no_an_err", 32'(anErr), 32'd0);
        dwell(8'hFC, enc(4'd9), 10);
        dwell(8'hFF, 8'hFF, 4);
        chk("an_err_set", 32'(anErr), 32'd1);
        chk("an_err_digits", 32'(digits()), 32'h1236);
        // scanning stops
        dwell(8'hFF, 8'hFF, TO - 500);
        chk("before_timeout_valid", 32'(timeVal), 32'd1);
        dwell(8'hFF, 8'hFF, 600);
        chk("timeout_valid", 32'(timeVal), 32'd0);
        chk("timeout_digits", 32'(digits()), 32'h1236);
        chk("timeout_colon", 32'(colonOn), 32'd1);
        frame(4'd1, 4'd2, 4'd3, 4'd6, 1'b1);
        frame(4'd1, 4'd2, 4'd3, 4'd6, 1'b1);
        chk("resume_two_frames", 32'(timeVal), 32'd0);
        frame(4'd1, 4'd2, 4'd3, 4'd6, 1'b1);
        chk("resume_valid", 32'(timeVal), 32'd1);
        chk("resume_pulses", 32'(pulses), 32'd4);
        // reset in the middle of a frame
        dwell(8'hFE, enc(4'd4), 50);
        dwell(8'hFD, enc(4'd3), 50);
        dwell(8'hFB, 8'h24, 20);
        rstN = 1'b0;
        #2;
        chk("midreset_digits", 32'(digits()), 32'h0);
        chk("midreset_flags", {27'd0, colonOn, timeVal, newTime, segErr, anErr}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        dwell(8'hFB, 8'h24, 30);
        dwell(8'hF7, enc(4'd1), 50);
        frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        chk("post_reset_two_frames", 32'(timeVal), 32'd0);
        frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        chk("post_reset_valid", 32'(timeVal), 32'd1);
        chk("post_reset_digits", 32'(digits()), 32'h1234);
        chk("post_reset_pulses", 32'(pulses), 32'd5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
